// File: rtl/fcs_generator.sv
// fcs_generator: forwards a framed byte stream and appends the Ethernet CRC-32
// FCS (4 bytes, LSB first) after the last payload byte.
// Optional: FCS_GENERATOR_MIN_PAD_EN pads short frames with 0x00 bytes up to
// MIN_FRAME_BYTES before the FCS is appended.
module fcs_generator #(
  parameter int DATA_WIDTH      = 8,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_of_frame,
  input  logic                  end_of_frame,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  frame_abort
);
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  generate
    if (DATA_WIDTH != 8 || MIN_FRAME_BYTES < 1) begin : g_param_chk
      $error("fcs_generator: only DATA_WIDTH = 8 and MIN_FRAME_BYTES >= 1 are supported");
    end
  endgenerate

`ifdef FCS_GENERATOR_MIN_PAD_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, APPEND, PAD} state_t;
  localparam int CW = $clog2(MIN_FRAME_BYTES + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD, APPEND} state_t;
`endif

  state_t      state_q, state_d, eof_tgt;
  logic [31:0] crc_q, crc_d, fcs;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  dout_d;
  logic        vld_d, sof_d, eof_d, abort_d;
  logic        ld, xfer, take;

  // One byte of the reflected CRC-32, bit 0 of the byte first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  assign ld   = !out_valid || out_ready;
`ifdef FCS_GENERATOR_MIN_PAD_EN
  assign in_ready = ld && state_q != APPEND && state_q != PAD;
  // Payload count including the byte being taken now, saturating at the minimum.
  assign cnt_nxt  = start_of_frame ? CW'(1) :
                    (cnt_q == CW'(MIN_FRAME_BYTES)) ? cnt_q : cnt_q + CW'(1);
  assign eof_tgt  = (cnt_nxt < CW'(MIN_FRAME_BYTES)) ? PAD : APPEND;
`else
  assign in_ready = ld && state_q != APPEND;
  assign eof_tgt  = APPEND;
`endif
  assign xfer = in_valid && in_ready;
  // Bytes outside a frame are swallowed; only SOF opens one from IDLE.
  assign take = xfer && (start_of_frame || state_q == PAYLOAD);
  assign fcs  = ~crc_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PAYLOAD: if (take) state_d = end_of_frame ? eof_tgt : PAYLOAD;
      APPEND:        if (ld && idx_q == 2'd3) state_d = IDLE;
`ifdef FCS_GENERATOR_MIN_PAD_EN
      PAD:           if (ld && cnt_q + CW'(1) >= CW'(MIN_FRAME_BYTES)) state_d = APPEND;
`endif
      default:       state_d = IDLE;
    endcase
  end

  // Output register and CRC datapath next values; everything holds while stalled.
  always_comb begin
    crc_d   = crc_q;
    idx_d   = idx_q;
    dout_d  = data_out;
    vld_d   = out_valid;
    sof_d   = out_sof;
    eof_d   = out_eof;
    abort_d = 1'b0;
`ifdef FCS_GENERATOR_MIN_PAD_EN
    cnt_d   = cnt_q;
`endif
    if (ld) begin
      vld_d = 1'b0;
      sof_d = 1'b0;
      eof_d = 1'b0;
      case (state_q)
        IDLE, PAYLOAD: begin
          if (take) begin
            vld_d   = 1'b1;
            sof_d   = start_of_frame;
            dout_d  = data_in[7:0];
            crc_d   = crc_upd(start_of_frame ? CRC_INIT : crc_q, data_in[7:0]);
            idx_d   = 2'd0;
            abort_d = start_of_frame && state_q == PAYLOAD;
`ifdef FCS_GENERATOR_MIN_PAD_EN
            cnt_d   = cnt_nxt;
`endif
          end
        end
        APPEND: begin
          vld_d  = 1'b1;
          dout_d = fcs[{idx_q, 3'b000} +: 8];
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            eof_d = 1'b1;
            crc_d = CRC_INIT;
          end
        end
`ifdef FCS_GENERATOR_MIN_PAD_EN
        PAD: begin
          vld_d  = 1'b1;
          dout_d = 8'h00;
          crc_d  = crc_upd(crc_q, 8'h00);
          cnt_d  = cnt_q + CW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q       <= CRC_INIT;
      idx_q       <= 2'd0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      frame_abort <= 1'b0;
`ifdef FCS_GENERATOR_MIN_PAD_EN
      cnt_q       <= '0;
`endif
    end else begin
      crc_q       <= crc_d;
      idx_q       <= idx_d;
      data_out    <= DATA_WIDTH'(dout_d);
      out_valid   <= vld_d;
      out_sof     <= sof_d;
      out_eof     <= eof_d;
      frame_abort <= abort_d;
`ifdef FCS_GENERATOR_MIN_PAD_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
endmodule

// File: doc/fcs_generator.md
Name: fcs_generator

Overview:
- Transmit-side counterpart of the serial FCS checker.
- Accepts a byte stream framed by start_of_frame/end_of_frame, forwards it unchanged, computes Ethernet CRC-32 on the fly, and appends the 4-byte FCS after the last payload byte.
- Its output stream is suitable for the FCS checker, which reports fcs_error = 0 for it.
- Sits between the frame source and the line/loopback path.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/data_out; only 8 is supported, other values are an elaboration error.
- MIN_FRAME_BYTES, 60, minimum payload length, used only with the padding feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_of_frame  input  1  marks the first payload byte; qualified by in_valid.
- end_of_frame  input  1  marks the last payload byte; qualified by in_valid; may coincide with start_of_frame.
- data_in  input  DATA_WIDTH  payload byte.
- in_valid  input  1  data_in/start_of_frame/end_of_frame valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- data_out  output  DATA_WIDTH  payload or FCS byte.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out.
- out_sof  output  1  first byte of output frame.
- out_eof  output  1  last FCS byte of output frame.
- frame_abort  output  1  one-cycle pulse: frame truncated by an unexpected start_of_frame.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; CRC = 0xFFFFFFFF; byte counter = 0.
  - out_valid, out_sof, out_eof, frame_abort = 0; data_out = 0.
- Output register load enable: ld = !out_valid || out_ready.
- in_ready = ld && state != APPEND, and state != PAD when padding is compiled in.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- CRC: reflected CRC-32, polynomial 0xEDB88320 (normal form 0x04C11DB7), LSB-first per byte, init 0xFFFFFFFF. The FCS is the ones-complement of the final CRC. FCS is sent least-significant byte first: fcs[7:0], then [15:8], [23:16], [31:24].
- Latency: a transferred input byte appears on data_out on the next cycle, with out_valid = 1, if ld held.
- States:
  - IDLE:
    - A transfer with start_of_frame = 1 seeds the CRC with that byte from 0xFFFFFFFF, drives out_sof = 1, and goes to PAYLOAD.
    - If end_of_frame is also 1, it goes directly to APPEND.
    - A transfer without start_of_frame is accepted and discarded: no output, CRC unchanged.
  - PAYLOAD:
    - Each transfer updates the CRC and outputs the byte.
    - end_of_frame = 1 goes to APPEND with fcs_idx = 0.
  - APPEND:
    - Each ld cycle outputs FCS byte fcs_idx and increments it.
    - Byte 3 has out_eof = 1; the next state is IDLE and the CRC reloads 0xFFFFFFFF.
    - No input is accepted.
- start_of_frame in PAYLOAD:
  - The old frame ends without FCS and without out_eof; frame_abort pulses for one cycle.
  - The new byte restarts the CRC, drives out_sof = 1, and the block stays in PAYLOAD.
- Backpressure: when out_ready = 0 and out_valid = 1, data_out, out_sof, out_eof and CRC state hold stable; in_ready = 0.
- end_of_frame with start_of_frame: a 1-byte frame, giving a 5-byte output.
- Back-to-back frames: the IDLE cycle after out_eof is not required. A transfer in the same cycle as the last FCS output, while transitioning to IDLE, is not allowed: in_ready = 0 in APPEND. Minimum gap is therefore 0 idle output cycles beyond the FCS.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: FCS_GENERATOR_MIN_PAD_EN.
- Defined:
  - The byte counter counts payload bytes, saturating at MIN_FRAME_BYTES.
  - If end_of_frame arrives with count < MIN_FRAME_BYTES, state PAD emits 0x00 bytes, each included in the CRC, until the total payload equals MIN_FRAME_BYTES; the block then enters APPEND.
  - in_ready = 0 in PAD.
- Undefined: no PAD state and no counter; frames of any length get the FCS directly.

Test Plan:
- Frame "123456789" (0x31..0x39), out_ready = 1 -> output is those 9 bytes, then 0x26 0x39 0xF4 0xCB; out_eof on 0xCB; latency 1 cycle; checker fcs_error = 0.
- Single byte 0x00 with start_of_frame = end_of_frame = 1 -> output 0x00, 0x8D, 0xEF, 0x02, 0xD2; out_sof and out_eof set on the first and last bytes.
- "123456789" with out_ready toggled pseudo-randomly (about 50%) -> identical byte sequence; data_out stable while stalled; no byte lost or duplicated.
- 5 payload bytes, then start_of_frame again before end_of_frame -> frame_abort pulses once; first frame has no FCS and no out_eof; second frame's FCS is correct.
- Reset asserted during APPEND (after 2 FCS bytes) -> outputs 0 asynchronously; the next frame "123456789" still yields 0x26 0x39 0xF4 0xCB.
- With FCS_GENERATOR_MIN_PAD_EN: 1-byte frame 0xAA -> 0xAA plus 59 bytes 0x00 plus 4 FCS bytes (64 total), matching the reference CRC model; a 60-byte frame gets no padding.
